// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite ROM arbiter.
package sprite_pkg;
    localparam int ROM_ADDR_W = 10;
    localparam int ROM_DATA_W = 8;
    localparam int ROM_LAT    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);
    int c;

    // Scan from the farthest candidate down to the nearest so the nearest wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = N; i >= 1; i--) begin
            c = (int'(last) + i) % N;
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin, burst-capped sharing of one single-port sprite ROM between NREQ fetch engines,
// with a tag pipeline that routes each returned pixel word back to the requester that issued it.
module sprite_rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = sprite_pkg::ROM_ADDR_W,
    parameter int DATA_W    = sprite_pkg::ROM_DATA_W,
    parameter int ROM_LAT   = sprite_pkg::ROM_LAT,
    parameter int MAX_BURST = 34
) (
    input  logic                   i_clk2,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*ADDR_W-1:0] i_addr,
    output logic [NREQ-1:0]        o_gnt,
    output logic [ADDR_W-1:0]      o_rom_addr,
    input  logic [DATA_W-1:0]      i_rom_data,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [NREQ-1:0]        o_rvalid,
    output logic                   o_busy
);
    import sprite_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e                    state_q, state_d;
    logic [IW-1:0]                 owner_q, owner_d;
    logic [IW-1:0]                 last_q, last_d;
    logic [CW-1:0]                 burst_q, burst_d;
    logic [ADDR_W-1:0]             rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0][NREQ-1:0]    tag_q, tag_d;
    logic [NREQ-1:0]               rvalid_q, rvalid_d;

    logic [ADDR_W-1:0]             addr_arr [NREQ];
    logic [NREQ-1:0]               owner_oh;
    logic [NREQ-1:0]               pick_req;
    logic [IW-1:0]                 pick_last;
    logic                          pick_found;
    logic [IW-1:0]                 pick_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
        assign addr_arr[gi] = i_addr[gi*ADDR_W +: ADDR_W];
    end

    assign owner_oh = NREQ'(1) << owner_q;

    // While owned, the picker only sees the other requesters and searches from the owner onward.
    assign pick_req  = (state_q == OWNED) ? (i_req & ~owner_oh) : i_req;
    assign pick_last = (state_q == OWNED) ? owner_q : last_q;

    rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
        .req   (pick_req),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        burst_d    = burst_q;
        rom_addr_d = rom_addr_q;
        tag_d      = {tag_q[ROM_LAT-1:0], {NREQ{1'b0}}};
        rvalid_d   = tag_q[ROM_LAT];
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    owner_d = pick_idx;
                end
            end
            OWNED: begin
                if (i_req[owner_q]) begin
                    rom_addr_d = addr_arr[owner_q];
                    tag_d[0]   = owner_oh;
                    if (burst_q == CW'(MAX_BURST - 1)) begin
                        // A full burst only hands over when someone is waiting; otherwise the count wraps.
                        burst_d = '0;
                        if (pick_found) begin
                            last_d  = owner_q;
                            owner_d = pick_idx;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    last_d  = owner_q;
                    burst_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IW'(NREQ - 1);
            burst_q    <= '0;
            rom_addr_q <= '0;
            tag_q      <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            rom_addr_q <= rom_addr_d;
            tag_q      <= tag_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign o_gnt      = (state_q == OWNED) ? owner_oh : '0;
    assign o_rom_addr = rom_addr_q;
    assign o_rdata    = i_rom_data;
    assign o_rvalid   = rvalid_q;
    assign o_busy     = (state_q == OWNED) || (|tag_q) || (|rvalid_q);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: requesters, a two-stage ROM model and a
// transaction-level model of ownership and read returns, compared every cycle.
module tb_sprite_rom_arbiter;
    localparam int NREQ      = 4;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 34;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        i_req;
    logic [NREQ*ADDR_W-1:0] i_addr;
    logic [NREQ-1:0]        o_gnt;
    logic [ADDR_W-1:0]      o_rom_addr;
    logic [DATA_W-1:0]      rom_d;
    logic [DATA_W-1:0]      o_rdata;
    logic [NREQ-1:0]        o_rvalid;
    logic                   o_busy;

    always #20 clk = ~clk;

    sprite_rom_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_clk2     (clk),
        .i_rst_n    (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .o_gnt      (o_gnt),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (rom_d),
        .o_rdata    (o_rdata),
        .o_rvalid   (o_rvalid),
        .o_busy     (o_busy)
    );

    // ROM: address sampled one edge after it is driven, data one edge later.
    logic [DATA_W-1:0] mem [1024];
    logic [ADDR_W-1:0] rom_a;
    always @(posedge clk) begin
        rom_a <= o_rom_addr;
        rom_d <= mem[rom_a];
    end

    typedef struct {
        int                due;
        int                k;
        logic [DATA_W-1:0] d;
    } ret_t;

    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                owner, bcnt, last;
    logic [ADDR_W-1:0] exp_addr;
    ret_t              q[$];
    int                left [NREQ];
    int                sent [NREQ];
    int                base [NREQ];
    int                rv_k[$];
    int                rv_c[$];
    int                rv_d[$];
    int                gnt_k[$];
    int                gnt_c[$];
    logic [NREQ-1:0]   prev_gnt;
    int                busy_last;

    function automatic int rr_next(input logic [NREQ-1:0] r, input int from);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(from + i) % NREQ]) return (from + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        bcnt     = 0;
        last     = NREQ - 1;
        exp_addr = '0;
        q.delete();
    endtask

    // Ownership rules applied to the inputs present at this edge.
    task automatic model_edge();
        logic [NREQ-1:0] others;
        ret_t r;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (owner < 0) begin
            if (i_req != 0) owner = rr_next(i_req, last);
        end else if (i_req[owner]) begin
            exp_addr = i_addr[owner*ADDR_W +: ADDR_W];
            r.due = cyc + 2;
            r.k   = owner;
            r.d   = mem[exp_addr];
            q.push_back(r);
            sent[owner]++;
            left[owner]--;
            bcnt++;
            others = i_req & ~(NREQ'(1) << owner);
            if (bcnt == MAX_BURST) begin
                bcnt = 0;
                if (others != 0) begin
                    last  = owner;
                    owner = rr_next(others, owner);
                end
            end
        end else begin
            last  = owner;
            bcnt  = 0;
            owner = (i_req != 0) ? rr_next(i_req, owner) : -1;
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] eg;
        eg = (owner >= 0) ? NREQ'(1) << owner : '0;
        chk("gnt", {28'd0, o_gnt}, {28'd0, eg});
        chk("rom_addr", {22'd0, o_rom_addr}, {22'd0, exp_addr});
        chk("busy", {31'd0, o_busy}, {31'd0, (owner >= 0) || (q.size() > 0)});
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rvalid", {28'd0, o_rvalid}, 32'(1) << q[0].k);
            chk("rdata", {24'd0, o_rdata}, {24'd0, q[0].d});
            $display("beat cycle=%0d req=%0d data=%02h", cyc, q[0].k, o_rdata);
            void'(q.pop_front());
        end else begin
            chk("rvalid_idle", {28'd0, o_rvalid}, 32'd0);
        end
        if (o_rvalid != 0) begin
            rv_k.push_back(oh_idx(o_rvalid));
            rv_c.push_back(cyc);
            rv_d.push_back(int'(o_rdata));
        end
        if (o_gnt != 0 && o_gnt !== prev_gnt) begin
            gnt_k.push_back(oh_idx(o_gnt));
            gnt_c.push_back(cyc);
        end
        prev_gnt = o_gnt;
        if (o_busy) busy_last = cyc;
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            i_req[k] = (left[k] > 0);
            i_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(base[k] + sent[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        compare();
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        rv_k.delete(); rv_c.delete(); rv_d.delete();
        gnt_k.delete(); gnt_c.delete();
        prev_gnt = o_gnt;
    endtask

    task automatic load(input int k, input int n, input int b);
        left[k] = n;
        sent[k] = 0;
        base[k] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = DATA_W'(a);
        for (int k = 0; k < NREQ; k++) load(k, 1, 0);
        rst_n    = 1'b0;
        i_req    = '0;
        i_addr   = '0;
        prev_gnt = '0;
        busy_last = 0;
        model_reset();
        drive();

        // Reset with all requests high, then first grant.
        steps(3);
        chk("t1_rst_gnt", {28'd0, o_gnt}, 32'd0);
        chk("t1_rst_rvalid", {28'd0, o_rvalid}, 32'd0);
        chk("t1_rst_addr", {22'd0, o_rom_addr}, 32'd0);
        clear_logs();
        rst_n = 1'b1;
        step();
        chk("t1_first_gnt", {28'd0, o_gnt}, 32'b0001);
        steps(20);
        chk("t1_gnt_count", gnt_k.size(), 4);
        for (int i = 0; i < 4 && i < gnt_k.size(); i++) chk("t1_gnt_order", gnt_k[i], i);

        // Single stream of 34 beats.
        do_reset();
        clear_logs();
        load(0, 34, 0);
        drive();
        steps(45);
        chk("t2_beats", rv_k.size(), 34);
        if (rv_k.size() == 34) begin
            chk("t2_first_data", rv_d[0], 32'h00);
            chk("t2_last_data", rv_d[33], 32'h21);
            chk("t2_contiguous", rv_c[33] - rv_c[0], 33);
            chk("t2_latency", rv_c[0] - gnt_c[0], 3);
        end

        // Burst cap hands over to requester 2 without a bubble.
        do_reset();
        clear_logs();
        load(0, 40, 32'h040);
        load(2, 3, 32'h080);
        drive();
        steps(60);
        chk("t3_beats", rv_k.size(), 43);
        if (rv_k.size() == 43) begin
            chk("t3_last_of_burst", rv_k[33], 0);
            chk("t3_handover", rv_k[34], 2);
            chk("t3_no_bubble", rv_c[34] - rv_c[33], 1);
            chk("t3_handover_data", rv_d[34], 32'h80);
        end

        // Round robin 0,1,2,3,0 with one beat each; requester 3 reads 0x3FF.
        do_reset();
        clear_logs();
        load(0, 1, 32'h010);
        load(1, 1, 32'h020);
        load(2, 1, 32'h030);
        load(3, 1, 32'h3FF);
        drive();
        for (int i = 0; i < 20 && left[0] != 0; i++) step();
        steps(2);
        left[0] = 1;
        drive();
        steps(20);
        chk("t4_gnt_count", gnt_k.size(), 5);
        chk("t4_rv_count", rv_k.size(), 5);
        if (gnt_k.size() == 5 && rv_k.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t4_gnt_order", gnt_k[i], i % 4);
                chk("t4_rv_order", rv_k[i], i % 4);
            end
            chk("t4_top_addr_data", rv_d[3], 32'hFF);
            chk("t4_reissue_data", rv_d[4], 32'h11);
        end

        // Reset while two reads are in flight.
        do_reset();
        clear_logs();
        load(1, 10, 32'h100);
        drive();
        for (int i = 0; i < 10 && sent[1] < 2; i++) step();
        chk("t5_two_accepted", sent[1], 2);
        rst_n = 1'b0;
        left[1] = 0;
        drive();
        steps(3);
        rst_n = 1'b1;
        steps(5);
        chk("t5_no_rvalid", rv_k.size(), 0);
        chk("t5_idle_gnt", {28'd0, o_gnt}, 32'd0);
        chk("t5_idle_busy", {31'd0, o_busy}, 32'd0);

        // Owner drops with nothing pending: idle, busy falls after the last return.
        do_reset();
        clear_logs();
        load(2, 3, 32'h200);
        drive();
        steps(12);
        chk("t6_beats", rv_k.size(), 3);
        chk("t6_gnt_idle", {28'd0, o_gnt}, 32'd0);
        chk("t6_busy_low", {31'd0, o_busy}, 32'd0);
        if (rv_k.size() == 3) chk("t6_busy_drain", busy_last, rv_c[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
